if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU. Holds the program counter, drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register. It sits directly upstream of the decode and control stage. It consumes the next-PC value produced by the PC-source multiplexer and returns PC+4 to it. It supports hazard stalls, branch/jump flushes and, optionally, an external interrupt redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IRQ_VECTOR, 32'h8000_0004, PC loaded when an interrupt is taken
- BUBBLE, 32'h0000_0000, instruction word inserted on flush (sll $0,$0,0)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- next_pc  in  32  next fetch address from PC-source mux (PC+4, branch, jump, jr, epc)
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  discard the word being fetched; IF/ID becomes bubble
- imem_addr  out  32  equals the PC register
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- pc_plus4  out  32  PC+4, combinational, fed back to PC-source mux
- ifid_instruction  out  32  registered instruction to decode
- ifid_pc_plus4  out  32  registered PC+4 of that instruction
- ifid_valid  out  1  1 = real instruction, 0 = bubble
- irq  in  1  level interrupt request
- eret  in  1  return-from-interrupt, one-cycle pulse from decode
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- epc  out  32  saved return address

## Operation
- Reset, sampled on the clock edge, sets the following: PC=RESET_PC, ifid_instruction=BUBBLE, ifid_pc_plus4=0, ifid_valid=0, epc=0, irq_ack=0, state=RUN.
- next_pc[1:0] is forced to 2'b00 on load. pc_plus4 = PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Per-cycle priority is reset > interrupt take > flush > stall > normal:
  - Interrupt take: PC<=IRQ_VECTOR, IF/ID<=bubble (valid=0), epc<=(flush ? next_pc : PC), irq_ack=1, state<=IN_ISR.
  - Flush: PC<=next_pc, IF/ID<=bubble. Flush overrides a simultaneous stall.
  - Stall: PC, IF/ID and epc hold.
  - Normal: PC<=next_pc, ifid_instruction<=imem_rdata, ifid_pc_plus4<=pc_plus4, ifid_valid<=1.
- Interrupt FSM:
  - RUN to IN_ISR: interrupt taken when state=RUN, irq=1 and stall=0. A stalled request waits.
  - IN_ISR to RUN: on eret=1. irq is ignored in IN_ISR and is not re-evaluated in the same cycle eret arrives, so the earliest next take is the following cycle.
  - eret in RUN is ignored.
- epc changes only on interrupt take.
- Reset asserted mid-ISR returns the FSM to RUN and clears epc.

## Timing
- imem_addr to instruction is a combinational read. The instruction is visible at ifid_instruction one cycle after its address is presented.
- Redirect latency is one cycle: next_pc presented in cycle N is fetched in cycle N+1.
- Flush produces exactly one bubble per asserted cycle.
- Stall of k cycles holds all outputs for k cycles.
- irq_ack is high for exactly the cycle following the take edge, i.e. registered; otherwise 0.
- No combinational path from irq, eret, stall or flush to any output.

## Configuration
- IF_STAGE_IRQ_EN defined: interrupt FSM, epc and irq_ack implemented as above.
- IF_STAGE_IRQ_EN undefined: irq and eret ports exist but are ignored; irq_ack is tied 0 and epc is tied 0; the FSM is removed; priority is reset > flush > stall > normal.

## Test plan
- Reset with RESET_PC=0, drive next_pc=pc_plus4 for 3 cycles: imem_addr goes 0, 4, 8, C; ifid_pc_plus4 follows one cycle later; ifid_valid goes 1 after the first edge.
- Stall at PC=8 for 2 cycles: imem_addr stays 8 and IF/ID holds the word from address 4; after release, imem_addr is C.
- Flush with next_pc=32'h40: next ifid_valid=0 and ifid_instruction=BUBBLE; imem_addr=40; the following edge registers the word at 40.
- Stall and flush in the same cycle with next_pc=32'h80: flush wins, giving imem_addr=80 and a bubble.
- With IRQ_EN defined, irq=1 at PC=10: imem_addr=8000_0004, epc=10, irq_ack pulses once, irq held high causes no second ack; eret with next_pc=epc gives imem_addr=10, and ack is re-allowed the next cycle.
- next_pc=32'h0000_0023: imem_addr=32'h0000_0020. With PC=32'hFFFF_FFFC, pc_plus4=0.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the pipelined MIPS CPU.
//
// Holds the program counter, presents it to instruction memory and registers
// the fetched word into the IF/ID pipeline register. Supports load-use stalls,
// branch/jump flushes and, when the macro IF_STAGE_IRQ_EN is defined, an
// external interrupt redirect with a saved return address.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   IRQ_VECTOR  PC loaded when an interrupt is taken
//   BUBBLE      instruction word inserted into IF/ID on flush (sll $0,$0,0)
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high
//   next_pc     [31:0] in  next fetch address from the PC-source mux
//   stall             in   hold PC and IF/ID
//   flush             in   replace the word being fetched with a bubble
//   imem_addr   [31:0] out PC register
//   imem_rdata  [31:0] in  instruction word (combinational read of imem_addr)
//   pc_plus4    [31:0] out PC+4, combinational, back to the PC-source mux
//   ifid_instruction [31:0] out registered instruction
//   ifid_pc_plus4    [31:0] out registered PC+4 of that instruction
//   ifid_valid        out  1 = real instruction, 0 = bubble
//   irq               in   level interrupt request
//   eret              in   return-from-interrupt pulse
//   irq_ack           out  one-cycle registered pulse when an interrupt is taken
//   epc         [31:0] out saved return address
//
// Handshake: there is no valid/ready pair here; stall is a hold request that
// freezes PC and IF/ID for every cycle it is high, flush overrides it, and an
// interrupt take (RUN state, irq high, stall low) overrides both.
//
// Configuration macro: IF_STAGE_IRQ_EN. When undefined, irq and eret are
// ignored, irq_ack and epc are tied 0 and the interrupt FSM is absent.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] BUBBLE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  input  logic        irq,
  input  logic        eret,
  output logic        irq_ack,
  output logic [31:0] epc
);

  logic [31:0] pc;
  logic [31:0] next_pc_aligned;
  logic        take;
  logic        unused_low_bits;

  // Fetch addresses are word aligned; the two low bits of next_pc are dropped.
  assign next_pc_aligned = {next_pc[31:2], 2'b00};
  assign unused_low_bits = ^next_pc[1:0];

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // PC and IF/ID register. Priority: reset > interrupt take > flush > stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_PC;
      ifid_instruction <= BUBBLE;
      ifid_pc_plus4    <= 32'h0;
      ifid_valid       <= 1'b0;
    end else if (take) begin
      pc               <= IRQ_VECTOR;
      ifid_instruction <= BUBBLE;
      ifid_pc_plus4    <= 32'h0;
      ifid_valid       <= 1'b0;
    end else if (flush) begin
      pc               <= next_pc_aligned;
      ifid_instruction <= BUBBLE;
      ifid_pc_plus4    <= 32'h0;
      ifid_valid       <= 1'b0;
    end else if (!stall) begin
      pc               <= next_pc_aligned;
      ifid_instruction <= imem_rdata;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
    end
  end

`ifdef IF_STAGE_IRQ_EN
  typedef enum logic {
    RUN    = 1'b0,
    IN_ISR = 1'b1
  } irq_state_t;

  irq_state_t state;

  // A stalled request waits; irq is not looked at while in the ISR, so the
  // cycle eret arrives can never also be a take.
  assign take = (state == RUN) && irq && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      epc     <= 32'h0;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= take;
      case (state)
        RUN: begin
          if (take) begin
            // When the current fetch is being flushed, the redirect target is
            // the instruction that should resume after the handler.
            epc   <= flush ? next_pc_aligned : pc;
            state <= IN_ISR;
          end
        end
        IN_ISR: begin
          if (eret) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_irq_inputs;

  assign take              = 1'b0;
  assign irq_ack           = 1'b0;
  assign epc               = 32'h0;
  assign unused_irq_inputs = irq ^ eret;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// Directed table of vectors, hand-written interrupt sequences, then random
// stimulus compared against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] BUBBLE     = 32'h0000_0000;
`ifdef IF_STAGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // clock / reset block
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        irq;
  logic        eret;
  logic        irq_ack;
  logic [31:0] epc;

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed hash of the address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = w(imem_addr);

  if_stage #(
    .RESET_PC  (RESET_PC),
    .IRQ_VECTOR(IRQ_VECTOR),
    .BUBBLE    (BUBBLE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .next_pc         (next_pc),
    .stall           (stall),
    .flush           (flush),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .pc_plus4        (pc_plus4),
    .ifid_instruction(ifid_instruction),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .irq             (irq),
    .eret            (eret),
    .irq_ack         (irq_ack),
    .epc             (epc)
  );

  // scoreboard counters
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  // driver: apply one cycle of inputs, sample 1 time unit after the edge
  task automatic step(input logic r, input logic [31:0] np, input logic st,
                      input logic fl, input logic iq, input logic er);
    reset   = r;
    next_pc = np;
    stall   = st;
    flush   = fl;
    irq     = iq;
    eret    = er;
    @(posedge clk);
    #1;
  endtask

  // behavioural model of the fetch stage
  logic [31:0] m_pc, m_instr, m_ipc4, m_epc;
  logic        m_valid, m_ack, m_isr;

  task automatic model_step(input logic r, input logic [31:0] np, input logic st,
                            input logic fl, input logic iq, input logic er);
    logic [31:0] target;
    logic        do_take;
    target = np & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = RESET_PC; m_instr = BUBBLE; m_ipc4 = 0; m_valid = 0;
      m_epc = 0; m_ack = 0; m_isr = 0;
      return;
    end
    do_take = IRQ_EN && !m_isr && iq && !st;
    m_ack = do_take;
    if (do_take) begin
      m_epc = fl ? target : m_pc;
      m_pc = IRQ_VECTOR; m_instr = BUBBLE; m_valid = 0; m_isr = 1;
    end else begin
      if (m_isr && er) m_isr = 0;
      if (fl) begin
        m_pc = target; m_instr = BUBBLE; m_valid = 0;
      end else if (!st) begin
        m_instr = w(m_pc); m_ipc4 = m_pc + 4; m_valid = 1; m_pc = target;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] npc;
    logic        st;
    logic        fl;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ipc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[12];

  initial begin
    reset = 1'b1; next_pc = 0; stall = 0; flush = 0; irq = 0; eret = 0;

    // rst npc st fl | addr valid ifid_pc_plus4 ifid_instruction
    vt[0]  = '{1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  BUBBLE};
    vt[1]  = '{1'b0, 32'h4,         1'b0, 1'b0, 32'h4,         1'b1, 32'h4,  w(32'h0)};
    vt[2]  = '{1'b0, 32'h8,         1'b0, 1'b0, 32'h8,         1'b1, 32'h8,  w(32'h4)};
    vt[3]  = '{1'b0, 32'hC,         1'b1, 1'b0, 32'h8,         1'b1, 32'h8,  w(32'h4)};
    vt[4]  = '{1'b0, 32'hC,         1'b1, 1'b0, 32'h8,         1'b1, 32'h8,  w(32'h4)};
    vt[5]  = '{1'b0, 32'hC,         1'b0, 1'b0, 32'hC,         1'b1, 32'hC,  w(32'h8)};
    vt[6]  = '{1'b0, 32'h40,        1'b0, 1'b1, 32'h40,        1'b0, 32'h0,  BUBBLE};
    vt[7]  = '{1'b0, 32'h44,        1'b0, 1'b0, 32'h44,        1'b1, 32'h44, w(32'h40)};
    vt[8]  = '{1'b0, 32'h80,        1'b1, 1'b1, 32'h80,        1'b0, 32'h0,  BUBBLE};
    vt[9]  = '{1'b0, 32'h23,        1'b0, 1'b0, 32'h20,        1'b1, 32'h84, w(32'h80)};
    vt[10] = '{1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h24, w(32'h20)};
    vt[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,  w(32'hFFFF_FFFC)};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      step(vt[i].rst, vt[i].npc, vt[i].st, vt[i].fl, 1'b0, 1'b0);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d pc_plus4", i), pc_plus4, vt[i].e_addr + 32'd4);
      check($sformatf("vec%0d ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vt[i].e_v});
      check($sformatf("vec%0d ifid_instruction", i), ifid_instruction, vt[i].e_instr);
      if (vt[i].e_v || vt[i].rst)
        check($sformatf("vec%0d ifid_pc_plus4", i), ifid_pc_plus4, vt[i].e_ipc4);
      check($sformatf("vec%0d irq_ack", i), {31'b0, irq_ack}, 32'h0);
      check($sformatf("vec%0d epc", i), epc, 32'h0);
    end

`ifdef IF_STAGE_IRQ_EN
    // interrupt sequences
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("irq pc at 10", imem_addr, 32'h10);
    step(1'b0, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
    check("irq stalled no ack", {31'b0, irq_ack}, 32'h0);
    check("irq stalled addr", imem_addr, 32'h10);
    step(1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    check("irq take addr", imem_addr, IRQ_VECTOR);
    check("irq take ack", {31'b0, irq_ack}, 32'h1);
    check("irq take epc", epc, 32'h10);
    check("irq take bubble", {31'b0, ifid_valid}, 32'h0);
    step(1'b0, 32'h8000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
    check("irq held no 2nd ack", {31'b0, irq_ack}, 32'h0);
    check("isr fetch addr", imem_addr, 32'h8000_0008);
    check("isr ifid instr", ifid_instruction, w(IRQ_VECTOR));
    step(1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1);
    check("eret addr", imem_addr, 32'h10);
    check("eret no ack", {31'b0, irq_ack}, 32'h0);
    check("eret epc holds", epc, 32'h10);
    step(1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    check("retake ack", {31'b0, irq_ack}, 32'h1);
    check("retake addr", imem_addr, IRQ_VECTOR);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset mid isr epc", epc, 32'h0);
    check("reset mid isr ack", {31'b0, irq_ack}, 32'h0);
    step(1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush take ack", {31'b0, irq_ack}, 32'h1);
    check("flush take epc", epc, 32'h40);
    check("flush take addr", imem_addr, IRQ_VECTOR);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ack one cycle", {31'b0, irq_ack}, 32'h0);
`else
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1);
    check("irq ignored addr", imem_addr, 32'h14);
    check("irq ignored ack", {31'b0, irq_ack}, 32'h0);
    check("irq ignored epc", epc, 32'h0);
    check("irq ignored valid", {31'b0, ifid_valid}, 32'h1);
`endif

    // random stimulus against the model
    for (int c = 0; c < 400; c++) begin
      logic        r, st, fl, iq, er;
      logic [31:0] np;
      r  = (c == 0) || ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      iq = ($urandom_range(0, 5) == 0);
      er = ($urandom_range(0, 9) == 0);
      np = ($urandom_range(0, 3) != 0) ? m_pc + 32'd4 : $urandom;
      if (c == 0) m_pc = RESET_PC;
      model_step(r, np, st, fl, iq, er);
      step(r, np, st, fl, iq, er);
      check($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      check($sformatf("rnd%0d ifid_valid", c), {31'b0, ifid_valid}, {31'b0, m_valid});
      check($sformatf("rnd%0d ifid_instruction", c), ifid_instruction, m_instr);
      if (m_valid)
        check($sformatf("rnd%0d ifid_pc_plus4", c), ifid_pc_plus4, m_ipc4);
      check($sformatf("rnd%0d irq_ack", c), {31'b0, irq_ack}, {31'b0, m_ack});
      check($sformatf("rnd%0d epc", c), epc, m_epc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
